// File: rtl/switch_egress_port.sv
// Egress end of the 4-port switch: filters ingress streams by target mask,
// buffers them in per-source hold registers and merges them round-robin into an output FIFO.
module switch_egress_port #(
  parameter  int unsigned PORT_ID    = 0,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    in_valid,
  input  logic [15:0]   in_source,
  input  logic [15:0]   in_target,
  input  logic [31:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_source,
  output logic [3:0]    out_target,
  output logic [7:0]    out_data,
  output logic [CW-1:0] fifo_count,
  output logic [7:0]    drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [3:0]    r_hv;
  logic [3:0]    r_hs [4];
  logic [3:0]    r_ht [4];
  logic [7:0]    r_hd [4];
  logic [1:0]    r_rr;
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic [7:0]    r_drop;

  logic [3:0]    w_req;
  logic [3:0]    w_grant;
  logic [3:0]    w_drop;
  logic [1:0]    w_gidx;
  logic          w_push;
  logic          w_pop;
  logic          w_push_ok;
  logic [15:0]   w_wdata;
  logic [15:0]   w_head;
  logic [2:0]    w_ndrop;
  logic [8:0]    w_drop_sum;

  always_comb begin
    w_req = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_req[i] = in_valid[i] && in_target[4*i + PORT_ID];
    end
  end

  assign w_pop     = out_valid && out_ready;
  assign w_push_ok = (r_count < DEPTH_C) || w_pop;

  always_comb begin
    logic [1:0] idx;
    logic       found;
    w_grant = '0;
    w_gidx  = '0;
    found   = 1'b0;
    idx     = '0;
    if (w_push_ok) begin
      for (int unsigned k = 0; k < 4; k++) begin
        idx = r_rr + 2'(k);
        if (!found && r_hv[idx]) begin
          found        = 1'b1;
          w_grant[idx] = 1'b1;
          w_gidx       = idx;
        end
      end
    end
  end

  assign w_push  = |w_grant;
  assign w_wdata = {4'b0000, r_hs[w_gidx], r_ht[w_gidx], r_hd[w_gidx]};

  // A granted hold register frees its slot in the same edge, so it can reload.
  assign w_drop = w_req & r_hv & ~w_grant;

  always_comb begin
    w_ndrop = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_ndrop = w_ndrop + {2'b00, w_drop[i]};
    end
  end

  assign w_drop_sum = {1'b0, r_drop} + {6'b000000, w_ndrop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hv   <= '0;
      r_rr   <= '0;
      r_drop <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_hs[i] <= '0;
        r_ht[i] <= '0;
        r_hd[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_req[i] && (!r_hv[i] || w_grant[i])) begin
          r_hv[i] <= 1'b1;
          r_hs[i] <= in_source[4*i +: 4];
          r_ht[i] <= in_target[4*i +: 4];
          r_hd[i] <= in_data[8*i +: 8];
        end else if (w_grant[i]) begin
          r_hv[i] <= 1'b0;
        end
      end
      if (w_push) r_rr <= w_gidx + 2'd1;
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_wdata;
  end

  assign w_head     = r_mem[r_rd];
  assign out_valid  = (r_count != '0);
  assign out_source = out_valid ? w_head[15:12] : '0;
  assign out_target = out_valid ? w_head[11:8]  : '0;
  assign out_data   = out_valid ? w_head[7:0]   : '0;
  assign fifo_count = r_count;
  assign drop_count = r_drop;

endmodule

// File: doc/switch_egress_port.md
# switch_egress_port

Egress (receive) end of the 4-port switch fabric: it takes the per-port transmit streams produced by the ingress ports (valid, source, target mask, data) and keeps only packets whose target mask selects this port. Accepted packets are captured in per-source hold registers, merged round-robin into an output FIFO, and delivered to the local consumer through a valid/ready handshake. One instance sits behind each of the four switch outputs.

## Interface

- PORT_ID, 0, index of this egress port (0..3); selects bit PORT_ID of each target mask.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  bit i = ingress port i is presenting a packet this cycle. Each pulse is one cycle and is never held.
- in_source  input  16  source field of ingress port i at [4i+3:4i].
- in_target  input  16  target mask of ingress port i at [4i+3:4i].
- in_data  input  32  payload of ingress port i at [8i+7:8i].
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head when out_valid && out_ready.
- out_source  output  4  head source; 0 when out_valid=0.
- out_target  output  4  head target mask, passed unchanged; 0 when out_valid=0.
- out_data  output  8  head payload; 0 when out_valid=0.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- drop_count  output  8  packets lost to a full hold register; saturates at 255.

## Operation

- Match: req[i] = in_valid[i] && in_target[4i+PORT_ID]. An input with req[i]=0 is ignored and is not counted as a drop.
- Hold register i (1 entry: valid, source, target, data):
  - Loads at the clock edge if req[i] && (!hold_valid[i] || grant[i]).
  - If req[i] && hold_valid[i] && !grant[i], the packet is dropped and drop_count increments, saturating at 255.
  - Clears on grant[i] when no load occurs in the same cycle.
- Arbiter (combinational):
  - Grants at most one hold_valid[i] per cycle, and only when push_ok = (fifo_count < FIFO_DEPTH) || pop.
  - Search order is rr_ptr, rr_ptr+1, ... mod 4.
  - After a grant g, rr_ptr <= (g+1) mod 4. Without a grant, rr_ptr is unchanged.
- FIFO:
  - push = any grant; it writes {source, target, data} of the granted hold register.
  - pop = out_valid && out_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop when full or empty is legal: when full, the count stays unchanged; when empty, a push in the same cycle is not visible until the next cycle.
- out_valid = (fifo_count != 0). The head fields are gated to 0 when out_valid=0.
- Reset (asynchronous, at any time):
  - Outputs: out_valid=0, out_source/out_target/out_data=0, fifo_count=0, drop_count=0.
  - Internal: all hold_valid=0, rr_ptr=0, FIFO pointers=0.
  - In-flight packets are discarded.

## Timing

- Minimum latency is 2 cycles: a packet presented in cycle N is in its hold register after edge N+1, is written to the FIFO at edge N+2, and shows out_valid=1 in cycle N+2.
- Sustained throughput is 1 packet per cycle to the consumer.
- Simultaneous requests from k sources are serialized. With an empty FIFO and out_ready=1, the j-th granted packet appears in cycle N+1+j (j=1..k).
- A source can present a new packet every cycle without loss only if its hold register is granted every cycle.
- out_* holds stable while out_valid && !out_ready.
- Storage capacity before drops is FIFO_DEPTH + 4 (one per hold register).

## Test plan

- Single packet, PORT_ID=2, out_ready=1: in_valid=0001, in_target[3:0]=0100, source=0, data=0xA5 in cycle 0 -> out_valid in cycle 2 only, with out_source=0, out_target=0100, out_data=0xA5; drop_count=0.
- Filtering, PORT_ID=2: in_valid=0001 with target 1011 -> out_valid stays 0, fifo_count=0, drop_count=0.
- Broadcast collision, PORT_ID=0, out_ready=1: all 4 inputs valid in cycle 0, target 1111, data 0x10..0x13 -> out_source 0,1,2,3 in cycles 2..5. Then inputs 1 and 3 fire together -> order 1,3, since rr_ptr=0 after grant 3.
- Backpressure, FIFO_DEPTH=4, out_ready=0: source 1 sends 6 consecutive packets, data 0..5 -> fifo_count=4 with data 0..3, hold[1] holds 4, data 5 dropped, drop_count=1. Then raise out_ready -> data 0,1,2,3,4 delivered in order on consecutive cycles.
- Full with simultaneous push and pop: FIFO full, hold[2] valid, out_ready=1 for one cycle -> head popped, hold[2] pushed in the same edge, fifo_count stays 4, no drop.
- Reset mid-stream: assert rst while fifo_count=3 and two hold registers are valid -> out_valid=0, fifo_count=0, drop_count=0 immediately (asynchronous). After release, a new broadcast is served starting at source 0.
